// File: rtl/bdc_pkg.sv
// -----------------------------------------------------------------------------
// bdc_pkg
// Shared definitions for the tachometer front end and the register file.
//   TACH_W         width of one motor's tach pin pair (bit0 = A, bit1 = B)
//   CNT_WIDTH_DEF  default position counter width
//   step_e         quadrature step classification
//   step_of()      classify a filtered tach transition in Gray order
//                  00 -> 01 -> 11 -> 10 -> 00 (forward direction)
// -----------------------------------------------------------------------------
package bdc_pkg;

  localparam int TACH_W        = 2;
  localparam int CNT_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_UP,
    STEP_DOWN,
    STEP_ILLEGAL
  } step_e;

  // Successor of a tach state in the forward Gray sequence.
  function automatic logic [TACH_W-1:0] gray_next(input logic [TACH_W-1:0] s);
    case (s)
      2'b00:   gray_next = 2'b01;
      2'b01:   gray_next = 2'b11;
      2'b11:   gray_next = 2'b10;
      default: gray_next = 2'b00;
    endcase
  endfunction

  function automatic step_e step_of(input logic [TACH_W-1:0] old_s,
                                    input logic [TACH_W-1:0] new_s);
    if (old_s == new_s)
      step_of = STEP_NONE;
    else if ((old_s ^ new_s) == 2'b11)
      step_of = STEP_ILLEGAL;
    else if (new_s == gray_next(old_s))
      step_of = STEP_UP;
    else
      step_of = STEP_DOWN;
  endfunction

endpackage

// File: rtl/tach_filter.sv
// -----------------------------------------------------------------------------
// tach_filter
// Synchronises the asynchronous tach pair and accepts a new level only after
// it has been seen unchanged for FILTER_LEN consecutive cycles.
//   clk, resetn   system clock, asynchronous active-low reset
//   i_tach        raw tach pins
//   o_sync        synchronised tach level (the candidate new state)
//   o_filt        currently accepted tach state (the old state during an update)
//   o_filt_upd    high for the cycle in which o_sync is being accepted
//   o_first_upd   the update above is the priming load after reset
// -----------------------------------------------------------------------------
module tach_filter
  import bdc_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [TACH_W-1:0] i_tach,
  output logic [TACH_W-1:0] o_sync,
  output logic [TACH_W-1:0] o_filt,
  output logic              o_filt_upd,
  output logic              o_first_upd
);

  localparam int STB_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [STB_W-1:0] STB_MAX = STB_W'(FILTER_LEN - 1);

  logic [TACH_W-1:0] r_sync [SYNC_STAGES];
  logic [TACH_W-1:0] r_sync_prev;
  logic [STB_W-1:0]  r_stable;
  logic [TACH_W-1:0] r_filt;
  logic              r_primed;
  logic [TACH_W-1:0] w_sync;
  logic              w_same;
  logic              w_upd;

  // ---- synchroniser
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= i_tach;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_same = (w_sync == r_sync_prev);

  // An unprimed filter accepts any stable level, including 00, so the
  // channel primes even when the pins sit at the reset value of r_filt.
  // w_same keeps a level change from riding on a counter that saturated
  // while the previous level was still present.
  assign w_upd = w_same && (r_stable == STB_MAX) && ((w_sync != r_filt) || !r_primed);

  // ---- stability counter and accepted state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync_prev <= '0;
      r_stable    <= '0;
      r_filt      <= '0;
      r_primed    <= 1'b0;
    end else begin
      r_sync_prev <= w_sync;
      if (!w_same)
        r_stable <= '0;
      else if (r_stable != STB_MAX)
        r_stable <= r_stable + 1'b1;
      if (w_upd) begin
        r_filt   <= w_sync;
        r_primed <= 1'b1;
      end
    end
  end

  assign o_sync      = w_sync;
  assign o_filt      = r_filt;
  assign o_filt_upd  = w_upd;
  assign o_first_upd = w_upd && !r_primed;

endmodule

// File: rtl/tach_quad_counter.sv
// -----------------------------------------------------------------------------
// tach_quad_counter
// Per-motor tach front end: filtered quadrature decode into a wrapping signed
// position count, with a coherent snapshot for the SPI register file.
//   clk, resetn   system clock, asynchronous active-low reset
//   tach          raw quadrature pins (bit0 = A, bit1 = B)
//   clr           one-clk strobe, zero the count (wins over a same-cycle step)
//   snap          one-clk strobe, capture the count as it stood before this edge
//   err_clr       one-clk strobe, clear err (a same-cycle illegal step wins)
//   snap_count    snapshot served as the low/high tach bytes
//   count         live two's complement position count
//   dir           direction of last accepted step, 1 = up
//   err           sticky illegal-transition flag
// -----------------------------------------------------------------------------
module tach_quad_counter
  import bdc_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [TACH_W-1:0]    tach,
  input  logic                 clr,
  input  logic                 snap,
  input  logic                 err_clr,
  output logic [CNT_WIDTH-1:0] snap_count,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 dir,
  output logic                 err
);

  logic [TACH_W-1:0]           w_sync;
  logic [TACH_W-1:0]           w_filt;
  logic                        w_filt_upd;
  logic                        w_first_upd;
  step_e                       w_step;
  logic signed [CNT_WIDTH-1:0] r_count;
  logic [CNT_WIDTH-1:0]        r_snap;
  logic                        r_dir;
  logic                        r_err;

  tach_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_filter (
    .clk         (clk),
    .resetn      (resetn),
    .i_tach      (tach),
    .o_sync      (w_sync),
    .o_filt      (w_filt),
    .o_filt_upd  (w_filt_upd),
    .o_first_upd (w_first_upd)
  );

  // ---- decode: old accepted state against the one being accepted
  always_comb begin
    w_step = STEP_NONE;
    if (w_filt_upd && !w_first_upd)
      w_step = step_of(w_filt, w_sync);
  end

  // ---- count, direction, error and snapshot registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
      r_snap  <= '0;
      r_dir   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (clr)
        r_count <= '0;
      else if (w_step == STEP_UP)
        r_count <= r_count + CNT_WIDTH'(1);
      else if (w_step == STEP_DOWN)
        r_count <= r_count - CNT_WIDTH'(1);

      if (w_step == STEP_UP)
        r_dir <= 1'b1;
      else if (w_step == STEP_DOWN)
        r_dir <= 1'b0;

      if (w_step == STEP_ILLEGAL)
        r_err <= 1'b1;
      else if (err_clr)
        r_err <= 1'b0;

      if (snap)
        r_snap <= r_count;
    end
  end

  assign count      = r_count;
  assign snap_count = r_snap;
  assign dir        = r_dir;
  assign err        = r_err;

endmodule

// File: tb/tb_tach_quad_counter.sv
// -----------------------------------------------------------------------------
// tb_tach_quad_counter
// Self-checking bench for tach_quad_counter at default parameters. Inputs are
// driven and outputs sampled on the falling clock edge. Expected snapshot
// values are queued when snap is driven and compared when it is captured.
// -----------------------------------------------------------------------------
module tb_tach_quad_counter;

  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [1:0]    tach = 2'b00;
  logic          clr = 1'b0;
  logic          snap = 1'b0;
  logic          err_clr = 1'b0;
  logic [CW-1:0] snap_count;
  logic [CW-1:0] count;
  logic          dir;
  logic          err;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  logic [CW-1:0] m_cnt = '0;
  logic          m_dir = 1'b0;
  logic          m_err = 1'b0;
  logic [1:0]    t_cur = 2'b00;
  logic [1:0]    seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  logic [CW-1:0] exp_q [$];
  string         tag_q [$];

  always #5 clk = ~clk;

  tach_quad_counter dut (
    .clk        (clk),
    .resetn     (resetn),
    .tach       (tach),
    .clr        (clr),
    .snap       (snap),
    .err_clr    (err_clr),
    .snap_count (snap_count),
    .count      (count),
    .dir        (dir),
    .err        (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int pos(input logic [1:0] t);
    case (t)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_step(input logic [1:0] nt);
    int d;
    d = (pos(nt) - pos(t_cur) + 4) % 4;
    if (d == 1) begin
      m_cnt = m_cnt + 16'd1;
      m_dir = 1'b1;
    end else if (d == 3) begin
      m_cnt = m_cnt - 16'd1;
      m_dir = 1'b0;
    end else if (d == 2) begin
      m_err = 1'b1;
    end
    t_cur = nt;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic move(input logic [1:0] nt, input int hold);
    model_step(nt);
    tach = nt;
    tick(hold);
  endtask

  task automatic snap_sb(input string tag);
    exp_q.push_back(m_cnt);
    tag_q.push_back(tag);
    snap = 1'b1;
    tick(1);
    snap = 1'b0;
    chk(tag_q.pop_front(), 32'(snap_count), 32'(exp_q.pop_front()));
  endtask

  function automatic logic [1:0] fwd(input logic [1:0] t);
    return seq[(pos(t) + 1) % 4];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] exp_cnt [5];
    logic          exp_dir [5];
    logic [1:0]    pat     [5];
    logic [CW-1:0] pre;

    pat     = '{2'b01, 2'b11, 2'b01, 2'b00, 2'b10};
    exp_cnt = '{16'h0001, 16'h0002, 16'h0001, 16'h0000, 16'hFFFF};
    exp_dir = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    tick(3);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_snap",  32'(snap_count), 32'h0);
    chk("rst_dir",   32'(dir), 32'h0);
    chk("rst_err",   32'(err), 32'h0);
    resetn = 1'b1;
    tick(20);
    chk("prime_00_count", 32'(count), 32'h0);

    // basic stepping with snapshots
    for (int i = 0; i < 5; i++) begin
      move(pat[i], 20);
      snap_sb("step_snap");
      chk("step_count_tbl", 32'(count), 32'(exp_cnt[i]));
      chk("step_dir", 32'(dir), 32'(exp_dir[i]));
    end

    // back to 00 (wraps to 0), then a short glitch must be rejected
    move(2'b00, 20);
    chk("wrap_up_count", 32'(count), 32'(m_cnt));
    tach = 2'b01;
    tick(2);
    tach = 2'b00;
    tick(20);
    chk("glitch_count", 32'(count), 32'h0);
    chk("glitch_err",   32'(err), 32'h0);

    // a held edge lands exactly 7 clocks after the pin change
    tach = 2'b01;
    model_step(2'b01);
    tick(6);
    chk("lat_before7", 32'(count), 32'h0);
    tick(1);
    chk("lat_at7", 32'(count), 32'(m_cnt));
    tick(15);

    // illegal transitions
    move(2'b00, 20);
    move(2'b11, 20);
    chk("illegal_count", 32'(count), 32'(m_cnt));
    chk("illegal_err",   32'(err), 32'(m_err));
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    m_err = 1'b0;
    chk("errclr_err", 32'(err), 32'(m_err));
    tach = 2'b00;
    model_step(2'b00);
    tick(6);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("errclr_vs_illegal", 32'(err), 32'(m_err));
    chk("illegal2_count", 32'(count), 32'(m_cnt));
    tick(14);

    // clr, wrap down, wrap up, clr against a same-cycle step
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    m_cnt = '0;
    chk("clr_count", 32'(count), 32'h0);
    move(2'b10, 20);
    chk("wrap_down", 32'(count), 32'hFFFF);
    snap_sb("wrap_down_snap");
    move(2'b00, 20);
    chk("wrap_up", 32'(count), 32'h0000);
    tach = 2'b01;
    model_step(2'b01);
    tick(6);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    m_cnt = '0;
    chk("clr_vs_step", 32'(count), 32'h0000);
    chk("clr_vs_step_dir", 32'(dir), 32'(m_dir));
    tick(14);

    // run up to 0x00FF, then snapshot in the same cycle as a step
    for (int i = 0; i < 255; i++) move(fwd(t_cur), 8);
    tick(10);
    chk("pre_snap_count", 32'(count), 32'h00FF);
    pre = m_cnt;
    tach = fwd(t_cur);
    model_step(tach);
    tick(6);
    exp_q.push_back(pre);
    tag_q.push_back("snap_coherent");
    snap = 1'b1;
    tick(1);
    snap = 1'b0;
    chk(tag_q.pop_front(), 32'(snap_count), 32'(exp_q.pop_front()));
    chk("snap_live_count", 32'(count), 32'h0100);
    tick(14);

    // reset mid-operation with tach held at 11
    while (t_cur != 2'b11) move(fwd(t_cur), 20);
    resetn = 1'b0;
    tick(2);
    chk("midrst_count", 32'(count), 32'h0);
    chk("midrst_err",   32'(err), 32'h0);
    chk("midrst_snap",  32'(snap_count), 32'h0);
    resetn = 1'b1;
    m_cnt = '0;
    m_dir = 1'b0;
    m_err = 1'b0;
    tick(20);
    chk("reprime_count", 32'(count), 32'h0000);
    move(2'b10, 20);
    chk("reprime_step", 32'(count), 32'h0001);
    chk("reprime_dir",  32'(dir), 32'(m_dir));
    snap_sb("reprime_snap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
